bf_bit_array: RTL and testbench

- Parametrised bloom-filter bit array built on a true-dual-port 1-bit RAM.
- Two independent request ports, each supporting test / set / test-and-set / clear-bit with fixed 2-cycle response latency.
- Deterministic same-cycle cross-port ordering.
- Self-initialising bulk-clear engine that zeroes the array after reset or on request.
- Sits between the CXL type-3 request decoder (hash units) and the filter storage.

---
 rtl/bf_pkg.sv | 33 +++
 rtl/bf_ram_tdp.sv | 31 +++
 rtl/bf_bit_array.sv | 183 ++++++++++++++++++
 tb/tb_bf_bit_array.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// bf_pkg: shared definitions for the bloom-filter bit array.
//   bf_op_e    : request opcodes carried on a_op / b_op
//   bf_state_e : sweep / service FSM states
//   BF_RSP_LAT : cycles from accept to response
//   bf_op_writes / bf_op_wdata : per-opcode write enable and write data
package bf_pkg;

    typedef enum logic [1:0] {
        BF_TEST = 2'b00,
        BF_SET  = 2'b01,
        BF_TAS  = 2'b10,
        BF_CLR  = 2'b11
    } bf_op_e;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        IDLE  = 2'b01,
        CLEAR = 2'b10
    } bf_state_e;

    localparam int unsigned BF_RSP_LAT = 2;

    // Every opcode except TEST writes the bit.
    function automatic logic bf_op_writes(input logic [1:0] op);
        return op != BF_TEST;
    endfunction

    // SET and TEST_AND_SET write 1, CLEAR_BIT writes 0.
    function automatic logic bf_op_wdata(input logic [1:0] op);
        return op != BF_CLR;
    endfunction

endpackage

// File: rtl/bf_ram_tdp.sv
// bf_ram_tdp: behavioural true-dual-port RAM, 2**ADDR_W x 1 bit.
//   clk                  : clock
//   addr_a/we_a/wd_a     : port A address, write enable, write data
//   rd_a                 : port A registered read data (old data on write)
//   addr_b/we_b/wd_b/rd_b: same for port B
// Both ports read the pre-write contents. The caller never writes the same
// address from both ports in one cycle.
module bf_ram_tdp #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              we_a,
    input  logic              wd_a,
    output logic              rd_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              we_b,
    input  logic              wd_b,
    output logic              rd_b
);

    logic mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wd_a;
        if (we_b) mem[addr_b] <= wd_b;
        rd_a <= mem[addr_a];
        rd_b <= mem[addr_b];
    end

endmodule

// File: rtl/bf_bit_array.sv
// bf_bit_array: bloom-filter bit array with two request ports and a
// self-initialising bulk-clear engine.
//   clock, reset             : clock, asynchronous active-high reset
//   a_valid/a_ready          : port A request handshake
//   a_op/a_addr              : opcode (TEST/SET/TAS/CLEAR_BIT) and bit index
//   a_rsp_valid/a_rsp_hit    : response pulse 2 cycles after accept; bit value
//                              before this op's write
//   b_*                      : identical port B
//   clear_req                : level request for a bulk clear (sampled in IDLE)
//   clear_busy               : sweep (init or requested) in progress
//   clear_done               : one-cycle pulse when a sweep completes
//   stat_ops, stat_hits      : saturating statistics, present only when
//                              BF_BIT_ARRAY_STATS_EN is defined
module bf_bit_array #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned STAT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [1:0]        a_op,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_rsp_valid,
    output logic              a_rsp_hit,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_op,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_rsp_valid,
    output logic              b_rsp_hit,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
`ifdef BF_BIT_ARRAY_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_hits
`endif
);

    import bf_pkg::*;

    if (ADDR_W < 2 || STAT_W < 1) begin : g_param_check
        $error("bf_bit_array: ADDR_W must be >= 2 and STAT_W >= 1");
    end

    bf_state_e         state;
    logic [ADDR_W-2:0] cnt;
    logic              ready_q;
    logic              sweep;

    logic a_acc, b_acc, a_wr, b_wr, same_addr;
    logic ram_we_a, ram_we_b, ram_wd_a, ram_wd_b, ram_rd_a, ram_rd_b;
    logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;

    logic a_v1, b_v1, b_fwd1, b_fwd_val1;

    assign a_ready = ready_q;
    assign b_ready = ready_q;
    assign sweep   = (state != IDLE);

    // Accepts only happen in IDLE, so the sweep muxing never collides with requests.
    assign a_acc     = a_valid & ready_q;
    assign b_acc     = b_valid & ready_q;
    assign a_wr      = a_acc & bf_op_writes(a_op);
    assign b_wr      = b_acc & bf_op_writes(b_op);
    assign same_addr = a_acc & b_acc & (a_addr == b_addr);

    // Same-address collision: A is ordered first, so B's write is the one that
    // lands; A's enable is dropped and B's read result is patched with A's data.
    assign ram_addr_a = sweep ? {1'b0, cnt} : a_addr;
    assign ram_addr_b = sweep ? {1'b1, cnt} : b_addr;
    assign ram_we_a   = sweep | (a_wr & ~(same_addr & b_wr));
    assign ram_we_b   = sweep | b_wr;
    assign ram_wd_a   = ~sweep & bf_op_wdata(a_op);
    assign ram_wd_b   = ~sweep & bf_op_wdata(b_op);

    bf_ram_tdp #(.ADDR_W(ADDR_W)) u_ram (
        .clk    (clock),
        .addr_a (ram_addr_a),
        .we_a   (ram_we_a),
        .wd_a   (ram_wd_a),
        .rd_a   (ram_rd_a),
        .addr_b (ram_addr_b),
        .we_b   (ram_we_b),
        .wd_b   (ram_wd_b),
        .rd_b   (ram_rd_b)
    );

    // Sweep / service FSM with registered ready, busy and done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            cnt        <= '0;
            ready_q    <= 1'b0;
            clear_busy <= 1'b1;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                INIT, CLEAR: begin
                    if (cnt == '1) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        ready_q    <= 1'b1;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        cnt        <= '0;
                        ready_q    <= 1'b0;
                        clear_busy <= 1'b1;
                    end
                end
                default: begin
                    state      <= INIT;
                    cnt        <= '0;
                    ready_q    <= 1'b0;
                    clear_busy <= 1'b1;
                end
            endcase
        end
    end

    // Response pipeline: accept edge captures RAM old data, next edge presents it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_v1        <= 1'b0;
            b_v1        <= 1'b0;
            b_fwd1      <= 1'b0;
            b_fwd_val1  <= 1'b0;
            a_rsp_valid <= 1'b0;
            a_rsp_hit   <= 1'b0;
            b_rsp_valid <= 1'b0;
            b_rsp_hit   <= 1'b0;
        end else begin
            a_v1        <= a_acc;
            b_v1        <= b_acc;
            b_fwd1      <= same_addr & a_wr;
            b_fwd_val1  <= bf_op_wdata(a_op);
            a_rsp_valid <= a_v1;
            a_rsp_hit   <= a_v1 & ram_rd_a;
            b_rsp_valid <= b_v1;
            b_rsp_hit   <= b_v1 & (b_fwd1 ? b_fwd_val1 : ram_rd_b);
        end
    end

`ifdef BF_BIT_ARRAY_STATS_EN
    logic [1:0] ops_inc, hit_inc;
    logic       clr_entry;

    assign ops_inc   = {1'b0, a_acc} + {1'b0, b_acc};
    assign hit_inc   = {1'b0, a_rsp_valid & a_rsp_hit} + {1'b0, b_rsp_valid & b_rsp_hit};
    assign clr_entry = (state == IDLE) & clear_req;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] v,
                                                  input logic [1:0] inc);
        logic [STAT_W:0] s;
        s = {1'b0, v} + (STAT_W+1)'(inc);
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_ops  <= '0;
            stat_hits <= '0;
        end else if (clr_entry) begin
            stat_ops  <= '0;
            stat_hits <= '0;
        end else begin
            stat_ops  <= sat_add(stat_ops, ops_inc);
            stat_hits <= sat_add(stat_hits, hit_inc);
        end
    end
`endif

endmodule

// File: tb/tb_bf_bit_array.sv
// tb_bf_bit_array: scoreboard bench for bf_bit_array at ADDR_W=4.
// Expected hits come from a reference bit model updated in A-then-B order
// when each request is driven; responses are popped and checked on negedge,
// together with their arrival cycle.
module tb_bf_bit_array;
    import bf_pkg::*;

    localparam int unsigned AW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0]    a_op = '0, b_op = '0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_rsp_hit, b_rsp_hit;
    logic          clear_req = 1'b0;
    logic          clear_busy, clear_done;
`ifdef BF_BIT_ARRAY_STATS_EN
    logic [31:0]   stat_ops, stat_hits;
`endif

    bf_bit_array #(.ADDR_W(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_op        (a_op),
        .a_addr      (a_addr),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_hit   (a_rsp_hit),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_op        (b_op),
        .b_addr      (b_addr),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_hit   (b_rsp_hit),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done)
`ifdef BF_BIT_ARRAY_STATS_EN
        ,
        .stat_ops    (stat_ops),
        .stat_hits   (stat_hits)
`endif
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        hit;
        int unsigned due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic model [0:(1 << AW)-1];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_we_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard and checks value and arrival cycle.
    always @(negedge clock) begin
        exp_t e;
        if (a_rsp_valid) begin
            if (qa.size() == 0) check("a_unexpected_rsp", 1, 0);
            else begin
                e = qa.pop_front();
                check("a_rsp_hit", a_rsp_hit, e.hit);
                check("a_rsp_cycle", cyc, e.due);
            end
        end
        if (b_rsp_valid) begin
            if (qb.size() == 0) check("b_unexpected_rsp", 1, 0);
            else begin
                e = qb.pop_front();
                check("b_rsp_hit", b_rsp_hit, e.hit);
                check("b_rsp_cycle", cyc, e.due);
            end
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!a_ready && n < 100) begin
            sync();
            n++;
        end
        if (!a_ready) check("ready_timeout", 0, 1);
    endtask

    // Drives one cycle of requests (post-edge phase); updates the model A then B.
    task automatic issue(input logic av, input logic [1:0] aop, input logic [AW-1:0] aad,
                         input logic bv, input logic [1:0] bop, input logic [AW-1:0] bad);
        exp_t e;
        wait_ready();
        a_valid = av; a_op = aop; a_addr = aad;
        b_valid = bv; b_op = bop; b_addr = bad;
        if (av) begin
            e.hit = model[aad];
            e.due = cyc + BF_RSP_LAT;
            qa.push_back(e);
            if (aop != BF_TEST) model[aad] = (aop != BF_CLR);
        end
        if (bv) begin
            e.hit = model[bad];
            e.due = cyc + BF_RSP_LAT;
            qb.push_back(e);
            if (bop != BF_TEST) model[bad] = (bop != BF_CLR);
        end
        #2;
        last_we_cnt = int'(dut.ram_we_a) + int'(dut.ram_we_b);
        sync();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < (1 << AW); i++) model[i] = 1'b0;
    endtask

    // Counts negedges with clear_busy high until it drops, then checks the handoff.
    task automatic check_sweep(input string tag);
        int busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (clear_busy && !a_ready) busy++;
            else break;
        end
        check({tag, "_busy_cycles"}, busy, 8);
        check({tag, "_done_pulse"}, clear_done, 1);
        check({tag, "_ready"}, {a_ready, b_ready}, 2'b11);
        @(negedge clock);
        check({tag, "_done_single"}, clear_done, 0);
        sync();
    endtask

    initial begin
        clear_model();

        // Reset state
        #12;
        check("rst_ready", {a_ready, b_ready}, 2'b00);
        check("rst_rsp", {a_rsp_valid, b_rsp_valid, a_rsp_hit, b_rsp_hit}, 4'b0000);
        check("rst_busy_done", {clear_busy, clear_done}, 2'b10);
        check("rst_cnt", 32'(dut.cnt), 0);
`ifdef BF_BIT_ARRAY_STATS_EN
        check("rst_stats", stat_ops | stat_hits, 0);
`endif
        sync();
        reset = 1'b0;
        check_sweep("init");

        // Whole array reads zero after INIT (B covers the upper half)
        for (int i = 0; i < (1 << (AW-1)); i++)
            issue(1'b1, BF_TEST, AW'(i), 1'b1, BF_TEST, AW'(i + 8));

        // Back-to-back TAS on one address sees the prior write
        issue(1'b1, BF_TAS, 4'd5, 1'b0, BF_TEST, 4'd0);
        issue(1'b1, BF_TAS, 4'd5, 1'b0, BF_TEST, 4'd0);

        // Same cycle A SET / B TEST, same address: B sees A's write
        issue(1'b1, BF_SET, 4'd3, 1'b1, BF_TEST, 4'd3);
        issue(1'b1, BF_TEST, 4'd3, 1'b0, BF_TEST, 4'd0);

        // Same cycle A SET / B CLEAR_BIT: B wins, one write enable only
        issue(1'b1, BF_SET, 4'd7, 1'b1, BF_CLR, 4'd7);
        check("collide_one_we", last_we_cnt, 1);
        issue(1'b1, BF_TEST, 4'd7, 1'b1, BF_TAS, 4'd12);

        // Different addresses in one cycle are independent
        issue(1'b1, BF_TAS, 4'd12, 1'b1, BF_TAS, 4'd13);

        // Bulk clear with a response in flight
        issue(1'b1, BF_SET, 4'd1, 1'b1, BF_SET, 4'd2);
        issue(1'b1, BF_SET, 4'd9, 1'b0, BF_TEST, 4'd0);
        issue(1'b1, BF_TEST, 4'd1, 1'b0, BF_TEST, 4'd0);
        clear_req = 1'b1;
        sync();
        clear_req = 1'b0;
        clear_model();
        check_sweep("clear");
        issue(1'b1, BF_TEST, 4'd1, 1'b1, BF_TEST, 4'd2);
        issue(1'b1, BF_TEST, 4'd9, 1'b1, BF_TEST, 4'd13);

        // Reset in the middle of a sweep restarts INIT from zero
        repeat (3) sync();
        clear_req = 1'b1;
        sync();
        clear_req = 1'b0;
        repeat (4) sync();
        check("mid_sweep_cnt", 32'(dut.cnt), 4);
        reset = 1'b1;
        #2;
        check("mid_rst_cnt", 32'(dut.cnt), 0);
        check("mid_rst_busy", clear_busy, 1);
        sync();
        reset = 1'b0;
        clear_model();
        check_sweep("reinit");

        // Three ops, one hit
        issue(1'b1, BF_SET, 4'd11, 1'b0, BF_TEST, 4'd0);
        issue(1'b1, BF_TEST, 4'd11, 1'b1, BF_TEST, 4'd12);
        repeat (5) sync();
`ifdef BF_BIT_ARRAY_STATS_EN
        check("stat_ops", stat_ops, 3);
        check("stat_hits", stat_hits, 1);
`endif

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
